// File: rtl/elixirchip_es1_spu_op_addsub_pipe.sv
// elixirchip_es1_spu_op_addsub_pipe
//   Pipelined add/subtract operator for the ES1 SPU datapath. The carry chain
//   is cut into LATENCY segments, one per pipeline stage. Each stage adds its
//   slice of the operands using the carry registered by the previous stage.
//   The untouched upper operand bits and the finished lower result bits ride
//   along in skew registers.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   cke             : clock enable; 0 freezes every stage
//   s_sub, s_carry  : per-beat mode (0 add, 1 sub) and carry-in (sub: 1 = no borrow)
//   s_data0/1       : operands
//   s_clear/s_valid : clear request / beat valid (clear wins)
//   m_data, m_carry : result and carry out of the MSB
//   m_msb_c         : carry into the MSB
//   m_overflow      : signed overflow (m_msb_c ^ m_carry)
//   m_valid         : one-cycle pulse per accepted beat or clear
module elixirchip_es1_spu_op_addsub_pipe #(
  parameter int   LATENCY     = 2,
  parameter int   DATA_BITS   = 32,
  parameter type  data_t      = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA = '0,
  parameter logic CLEAR_CARRY = 1'b0,
  parameter logic CLEAR_MSB_C = 1'b0,
  parameter logic CLEAR_OVF   = 1'b0,
  parameter       DEVICE      = "RTL",
  parameter       SIMULATION  = "false",
  parameter       DEBUG       = "false"
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  cke,
  input  logic  s_sub,
  input  logic  s_carry,
  input  data_t s_data0,
  input  data_t s_data1,
  input  logic  s_clear,
  input  logic  s_valid,
  output data_t m_data,
  output logic  m_carry,
  output logic  m_msb_c,
  output logic  m_overflow,
  output logic  m_valid
);

  localparam int SEG = (DATA_BITS + LATENCY - 1) / LATENCY;

  // per-stage token registers
  logic [LATENCY-1:0] r_valid;
  logic [LATENCY-1:0] r_clear;
  logic [LATENCY-1:0] r_cy;
  logic [LATENCY-1:0] r_msbc;
  data_t              r_a   [LATENCY];
  data_t              r_b   [LATENCY];
  data_t              r_sum [LATENCY];
  logic               r_ovf;

  // per-stage incoming token and stage result
  logic [LATENCY-1:0] w_v_in;
  logic [LATENCY-1:0] w_c_in;
  logic [LATENCY-1:0] w_cy_in;
  logic [LATENCY-1:0] w_msbc_in;
  logic [LATENCY-1:0] w_cy_out;
  logic [LATENCY-1:0] w_msbc_out;
  data_t              w_a_in  [LATENCY];
  data_t              w_b_in  [LATENCY];
  data_t              w_s_in  [LATENCY];
  data_t              w_s_out [LATENCY];

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    localparam int LO = k * SEG;

    if (k == 0) begin : g_first
      // subtract is a + ~b + carry, so the inverted operand enters the chain here
      assign w_v_in[k]    = s_valid;
      assign w_c_in[k]    = s_clear;
      assign w_cy_in[k]   = s_carry;
      assign w_msbc_in[k] = s_carry;
      assign w_a_in[k]    = s_data0;
      assign w_b_in[k]    = s_sub ? ~s_data1 : s_data1;
      assign w_s_in[k]    = '0;
    end else begin : g_next
      assign w_v_in[k]    = r_valid[k-1];
      assign w_c_in[k]    = r_clear[k-1];
      assign w_cy_in[k]   = r_cy[k-1];
      assign w_msbc_in[k] = r_msbc[k-1];
      assign w_a_in[k]    = r_a[k-1];
      assign w_b_in[k]    = r_b[k-1];
      assign w_s_in[k]    = r_sum[k-1];
    end

    if (LO < DATA_BITS) begin : g_add
      localparam int HI = ((k + 1) * SEG < DATA_BITS) ? (k + 1) * SEG - 1 : DATA_BITS - 1;
      localparam int W  = HI - LO + 1;
      localparam data_t MASK = data_t'({W{1'b1}}) << LO;

      logic [W:0] w_seg;

      assign w_seg = {1'b0, w_a_in[k][HI:LO]} + {1'b0, w_b_in[k][HI:LO]}
                   + {{W{1'b0}}, w_cy_in[k]};
      assign w_cy_out[k] = w_seg[W];
      assign w_s_out[k]  = (w_s_in[k] & ~MASK) | (data_t'(w_seg[W-1:0]) << LO);

      if (HI == DATA_BITS - 1) begin : g_msb
        // carry into the MSB recovered from sum ^ a ^ b at that bit
        assign w_msbc_out[k] = w_seg[W-1] ^ w_a_in[k][DATA_BITS-1] ^ w_b_in[k][DATA_BITS-1];
      end else begin : g_no_msb
        assign w_msbc_out[k] = w_msbc_in[k];
      end
    end else begin : g_pass
      // trailing stage with no bits left: carry the finished result through
      assign w_cy_out[k]   = w_cy_in[k];
      assign w_msbc_out[k] = w_msbc_in[k];
      assign w_s_out[k]    = w_s_in[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_clear <= '0;
      r_cy    <= {LATENCY{CLEAR_CARRY}};
      r_msbc  <= {LATENCY{CLEAR_MSB_C}};
      r_ovf   <= CLEAR_OVF;
      for (int k = 0; k < LATENCY; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= CLEAR_DATA;
      end
    end else if (cke) begin
      r_valid <= w_v_in;
      r_clear <= w_c_in;
      for (int k = 0; k < LATENCY; k++) begin
        // idle tokens leave the stage contents alone so the result holds
        if (w_v_in[k] | w_c_in[k]) begin
          r_a[k] <= w_a_in[k];
          r_b[k] <= w_b_in[k];
          if (w_c_in[k]) begin
            r_sum[k]  <= CLEAR_DATA;
            r_cy[k]   <= CLEAR_CARRY;
            r_msbc[k] <= CLEAR_MSB_C;
          end else begin
            r_sum[k]  <= w_s_out[k];
            r_cy[k]   <= w_cy_out[k];
            r_msbc[k] <= w_msbc_out[k];
          end
        end
      end
      if (w_v_in[LATENCY-1] | w_c_in[LATENCY-1]) begin
        r_ovf <= w_c_in[LATENCY-1] ? CLEAR_OVF
                                   : (w_msbc_out[LATENCY-1] ^ w_cy_out[LATENCY-1]);
      end
    end
  end

  assign m_data     = r_sum[LATENCY-1];
  assign m_carry    = r_cy[LATENCY-1];
  assign m_msb_c    = r_msbc[LATENCY-1];
  assign m_overflow = r_ovf;
  assign m_valid    = r_valid[LATENCY-1] | r_clear[LATENCY-1];

endmodule

// File: tb/tb_elixirchip_es1_spu_op_addsub_pipe.sv
// tb_elixirchip_es1_spu_op_addsub_pipe
//   Drives one shared stimulus stream into several parameterisations of the
//   add/sub pipe (instance 0 is DATA_BITS=8, LATENCY=3). A queue-based
//   reference per instance predicts every output on every cycle; literal
//   expectations on instance 0 pin the reference to hand-computed values.
module tb_elixirchip_es1_spu_op_addsub_pipe;

  localparam int NCFG = 8;
  localparam int CFG_N [NCFG] = '{8, 1, 7, 7, 7, 64, 64, 64};
  localparam int CFG_L [NCFG] = '{3, 1, 1, 4, 7,  1,  4, 64};

  typedef struct {
    bit          tok;
    bit          clr;
    logic [63:0] d;
    bit          co;
    bit          mc;
    bit          ov;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cke = 1'b1;
  logic        s_sub = 1'b0;
  logic        s_carry = 1'b0;
  logic        s_clear = 1'b0;
  logic        s_valid = 1'b0;
  logic [63:0] sd0 = '0;
  logic [63:0] sd1 = '0;

  logic [63:0]     o_data [NCFG];
  logic [NCFG-1:0] o_carry;
  logic [NCFG-1:0] o_msbc;
  logic [NCFG-1:0] o_ovf;
  logic [NCFG-1:0] o_valid;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // full-width arithmetic reference for an n-bit operator
  function automatic void calc(input int n, input bit sub, input bit c,
                               input logic [63:0] a, input logic [63:0] b,
                               output logic [63:0] d, output bit co,
                               output bit mc, output bit ov);
    logic [64:0] m, lm, full, low;
    logic [63:0] bb;
    m    = (65'd1 << n) - 65'd1;
    lm   = (65'd1 << (n - 1)) - 65'd1;
    bb   = sub ? ~b : b;
    full = ({1'b0, a} & m) + ({1'b0, bb} & m) + 65'(c);
    d    = full[63:0] & m[63:0];
    co   = full[n];
    if (n == 1) mc = c;
    else begin
      low = ({1'b0, a} & lm) + ({1'b0, bb} & lm) + 65'(c);
      mc  = low[n-1];
    end
    ov = mc ^ co;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int N = CFG_N[g];
    localparam int L = CFG_L[g];

    logic [N-1:0] w_d;
    logic         w_co, w_mc, w_ov, w_v;

    elixirchip_es1_spu_op_addsub_pipe #(
      .LATENCY   (L),
      .DATA_BITS (N),
      .data_t    (logic [N-1:0])
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .cke        (cke),
      .s_sub      (s_sub),
      .s_carry    (s_carry),
      .s_data0    (sd0[N-1:0]),
      .s_data1    (sd1[N-1:0]),
      .s_clear    (s_clear),
      .s_valid    (s_valid),
      .m_data     (w_d),
      .m_carry    (w_co),
      .m_msb_c    (w_mc),
      .m_overflow (w_ov),
      .m_valid    (w_v)
    );

    assign o_data[g]  = 64'(w_d);
    assign o_carry[g] = w_co;
    assign o_msbc[g]  = w_mc;
    assign o_ovf[g]   = w_ov;
    assign o_valid[g] = w_v;

    beat_t       q[$];
    logic [63:0] e_d;
    bit          e_co, e_mc, e_ov, e_v;

    // beats enter a delay line of L enabled cycles; the one leaving updates the outputs
    always @(posedge clk) begin
      beat_t nb, ob;
      if (reset) begin
        q.delete();
        e_d = '0; e_co = 0; e_mc = 0; e_ov = 0; e_v = 0;
      end else if (cke) begin
        nb.tok = s_valid;
        nb.clr = s_clear;
        calc(N, s_sub, s_carry, sd0, sd1, nb.d, nb.co, nb.mc, nb.ov);
        q.push_back(nb);
        e_v = 0;
        if (q.size() == L) begin
          ob = q.pop_front();
          if (ob.tok || ob.clr) begin
            e_v = 1;
            if (ob.clr) begin
              e_d = '0; e_co = 0; e_mc = 0; e_ov = 0;
            end else begin
              e_d = ob.d; e_co = ob.co; e_mc = ob.mc; e_ov = ob.ov;
            end
          end
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        total++;
        if ({o_data[g], o_carry[g], o_msbc[g], o_ovf[g], o_valid[g]} !==
            {e_d, e_co, e_mc, e_ov, e_v}) begin
          bad++;
          $display("FAIL model_cfg%0d t=%0t: got d=%h c=%b mc=%b ov=%b v=%b, want d=%h c=%b mc=%b ov=%b v=%b",
                   g, $time, o_data[g], o_carry[g], o_msbc[g], o_ovf[g], o_valid[g],
                   e_d, e_co, e_mc, e_ov, e_v);
        end
      end
    end
  end

  task automatic step(input bit v, input bit clr, input bit sub, input bit c,
                      input logic [63:0] a, input logic [63:0] b, input bit ck);
    s_valid = v; s_clear = clr; s_sub = sub; s_carry = c;
    sd0 = a; sd1 = b; cke = ck;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, 1);
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    idle(n);
    reset = 0;
  endtask

  task automatic chk(input string nm, input logic [7:0] d, input bit co,
                     input bit mc, input bit ov, input bit v);
    total++;
    if ({o_data[0], o_carry[0], o_msbc[0], o_ovf[0], o_valid[0]} !==
        {56'd0, d, co, mc, ov, v}) begin
      bad++;
      $display("FAIL %s: got d=%h c=%b mc=%b ov=%b v=%b, want d=%h c=%b mc=%b ov=%b v=%b",
               nm, o_data[0], o_carry[0], o_msbc[0], o_ovf[0], o_valid[0], d, co, mc, ov, v);
    end
  endtask

  logic [7:0] st_a   [8] = '{8'hFF, 8'h10, 8'h40, 8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
  logic [7:0] st_b   [8] = '{8'h01, 8'h01, 8'h40, 8'h01, 8'h02, 8'h80, 8'h80, 8'hFF};
  bit         st_sub [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  bit         st_c   [8] = '{1, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1;
    do_reset(2);
    chk("reset_state", 8'h00, 0, 0, 0, 0);

    // add 0x7F + 0x01: positive overflow
    step(1, 0, 0, 0, 64'h7F, 64'h01, 1);
    idle(1);
    chk("add_early", 8'h00, 0, 0, 0, 0);
    idle(1);
    chk("add_7f_01", 8'h80, 0, 1, 1, 1);
    idle(1);
    chk("add_pulse_end", 8'h80, 0, 1, 1, 0);

    // 0x05 - 0x07 borrows
    step(1, 0, 1, 1, 64'h05, 64'h07, 1);
    idle(2);
    chk("sub_05_07", 8'hFE, 0, 0, 0, 1);

    // 0x80 - 0x01: negative overflow
    step(1, 0, 1, 1, 64'h80, 64'h01, 1);
    idle(2);
    chk("sub_80_01", 8'h7F, 1, 0, 1, 1);
    idle(3);

    // back-to-back alternating add/sub
    for (int i = 0; i < 8; i++) begin
      step(1, 0, st_sub[i], st_c[i], 64'(st_a[i]), 64'(st_b[i]), 1);
      if (i == 2) chk("stream_ff_01_c1", 8'h01, 1, 1, 0, 1);
      if (i == 3) chk("stream_10_m_01", 8'h0F, 1, 1, 0, 1);
    end
    idle(4);

    // same stream with random cke gaps; junk beats offered while stalled
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        step(1, $urandom_range(0, 1), 1, 1, {$urandom, $urandom}, {$urandom, $urandom}, 0);
      step(1, 0, st_sub[i], st_c[i], 64'(st_a[i]), 64'(st_b[i]), 1);
    end
    idle(70);

    // hold across idle beats, then clear beats a simultaneous valid
    step(1, 0, 0, 0, 64'h12, 64'h34, 1);
    idle(5);
    chk("hold_after_idle", 8'h46, 0, 0, 0, 0);
    step(1, 1, 0, 0, 64'h7F, 64'h01, 1);
    idle(2);
    chk("clear_wins", 8'h00, 0, 0, 0, 1);
    idle(1);
    chk("clear_pulse_end", 8'h00, 0, 0, 0, 0);

    // reset with two beats in flight
    step(1, 0, 0, 0, 64'h12, 64'h34, 1);
    step(1, 0, 0, 0, 64'h7F, 64'h01, 1);
    step(1, 0, 0, 1, 64'hFF, 64'h01, 1);
    chk("pre_reset_out", 8'h46, 0, 0, 0, 1);
    do_reset(1);
    chk("reset_flush", 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("no_pulse_after_reset", 8'h00, 0, 0, 0, 0);
    end
    idle(70);

    // random sweep across all parameterisations
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 1), ($urandom_range(0, 15) == 0), $urandom_range(0, 1),
           $urandom_range(0, 1), {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(0, 9) < 8));
    end
    reset = 0;
    idle(140);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
